// File: rtl/aes_key_schedule_ctrl_pkg.sv
// Shared definitions for the AES key-schedule controller.
//   - algorithm encodings and the FSM state type
//   - Nk / Nr / Nw lookup helpers per algorithm
//   - GF(2^8) helpers, S-box, SubWord and Rcon used by the one-step expansion
package aes_key_schedule_ctrl_pkg;

    localparam logic [1:0] ALG_128 = 2'b00;
    localparam logic [1:0] ALG_192 = 2'b01;
    localparam logic [1:0] ALG_256 = 2'b10;
    localparam logic [1:0] ALG_ILL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2,
        ST_DONE   = 2'd3
    } ks_state_e;

    // Key length in 32-bit words.
    function automatic logic [3:0] nk_of(input logic [1:0] alg);
        case (alg)
            ALG_128: return 4'd4;
            ALG_192: return 4'd6;
            default: return 4'd8;
        endcase
    endfunction

    // Number of rounds.
    function automatic logic [3:0] nr_of(input logic [1:0] alg);
        case (alg)
            ALG_128: return 4'd10;
            ALG_192: return 4'd12;
            default: return 4'd14;
        endcase
    endfunction

    // Total schedule length in words: 4 * (Nr + 1).
    function automatic logic [5:0] nw_of(input logic [1:0] alg);
        case (alg)
            ALG_128: return 6'd44;
            ALG_192: return 6'd52;
            default: return 6'd60;
        endcase
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed as affine(x^254); x^254 is the GF(2^8) inverse and maps 0 to 0.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gf_mul(inv, inv);
            if (i != 0) inv = gf_mul(inv, b);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Round constant for iteration 1..10.
    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/Key_Expansion_new.sv
// Combinational one-step AES key expansion.
// Ports:
//   in        256  current Nk words, left-justified (word 0 in [255:224])
//   i_Nk      4    iteration number 1..10 (selects Rcon)
//   Algorithm 2    00=AES-128, 01=AES-192, 10=AES-256
//   out       256  next Nk words, same format as in; unused low words are zero
module Key_Expansion_new
    import aes_key_schedule_ctrl_pkg::*;
(
    input  logic [255:0] in,
    input  logic [3:0]   i_Nk,
    input  logic [1:0]   Algorithm,
    output logic [255:0] out
);

    logic [31:0] w [8];
    logic [31:0] n [8];
    logic [31:0] last_w;
    logic [31:0] temp;

    // NOTE: every signal driven here gets a value before any conditional code, so no latch is inferred.
    always_comb begin
        out = '0;
        for (int j = 0; j < 8; j++) w[j] = in[255-32*j -: 32];

        last_w = (Algorithm == ALG_128) ? w[3] :
                 (Algorithm == ALG_192) ? w[5] : w[7];
        temp   = sub_word({last_w[23:0], last_w[31:24]}) ^ {rcon(i_Nk), 24'h000000};

        n[0] = w[0] ^ temp;
        n[1] = w[1] ^ n[0];
        n[2] = w[2] ^ n[1];
        n[3] = w[3] ^ n[2];
        // AES-256 applies a plain SubWord (no rotate, no Rcon) at the half-block boundary.
        n[4] = (Algorithm == ALG_256) ? (w[4] ^ sub_word(n[3])) : (w[4] ^ n[3]);
        n[5] = w[5] ^ n[4];
        n[6] = w[6] ^ n[5];
        n[7] = w[7] ^ n[6];

        for (int j = 0; j < 8; j++) begin
            if (j < int'(nk_of(Algorithm))) out[255-32*j -: 32] = n[j];
        end
    end

endmodule

// File: rtl/aes_rk_buffer.sv
// Key-schedule register file, MAX_WORDS x 32 bits.
// Ports:
//   clk, rst    clock; synchronous active-high reset (read register only)
//   we_i        per-word write enables for up to 8 words
//   wbase_i     address of word 0 of the write group
//   wdata_i     8 words, left-justified (word 0 in [255:224])
//   round_i     round index; reads words 4*round_i .. 4*round_i+3
//   rd_zero_i   force the read result to zero
//   rdata_o     registered 128-bit round key
module aes_rk_buffer #(
    parameter int MAX_WORDS = 60
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   we_i,
    input  logic [5:0]   wbase_i,
    input  logic [255:0] wdata_i,
    input  logic [3:0]   round_i,
    input  logic         rd_zero_i,
    output logic [127:0] rdata_o
);

    logic [31:0]  mem_q [MAX_WORDS];
    logic [127:0] rdata_q;
    logic [127:0] rdata_d;
    logic [5:0]   rd_base;

    // NOTE: storage is deliberately left out of reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        for (int j = 0; j < 8; j++) begin
            if (we_i[j] && (int'(wbase_i) + j < MAX_WORDS)) begin
                mem_q[wbase_i + 6'(j)] <= wdata_i[255-32*j -: 32];
            end
        end
    end

    assign rd_base = {round_i, 2'b00};

    always_comb begin
        rdata_d = '0;
        if (!rd_zero_i) begin
            for (int j = 0; j < 4; j++) begin
                if (int'(rd_base) + j < MAX_WORDS) rdata_d[127-32*j -: 32] = mem_q[rd_base + 6'(j)];
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// Sequential AES-128/192/256 key-schedule controller.
// Accepts a key over valid/ready, runs Key_Expansion_new once per clock,
// stores the expanded schedule and serves registered round keys by index.
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   key_in       cipher key, left-justified
//   alg          00=AES-128, 01=AES-192, 10=AES-256, 11=illegal
//   key_valid    key_in/alg valid
//   key_ready    key can be accepted (IDLE or DONE)
//   rk_idx       round-key index 0..nr
//   rk_out       registered round key for rk_idx (zero when rk_idx > nr)
//   keys_ready   schedule complete for the current key
//   nr           round count of the loaded key
//   alg_err      one-cycle pulse after a handshake with alg=11
module aes_key_schedule_ctrl
    import aes_key_schedule_ctrl_pkg::*;
#(
    parameter int MAX_WORDS = 60
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] key_in,
    input  logic [1:0]   alg,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out,
    output logic         keys_ready,
    output logic [3:0]   nr,
    output logic         alg_err
);

    ks_state_e    state_q, state_d;
    logic [255:0] key_q, key_d;
    logic [1:0]   alg_q, alg_d;
    logic [5:0]   wptr_q, wptr_d;
    logic [3:0]   iter_q, iter_d;
    logic         keys_ready_q, keys_ready_d;
    logic [3:0]   nr_q, nr_d;
    logic         alg_err_q, alg_err_d;

    logic         handshake;
    logic         accept;
    logic [255:0] step_out;
    logic [3:0]   nk;
    logic [5:0]   nw;
    logic [6:0]   wptr_next;
    logic         buf_wr;
    logic [7:0]   buf_we;
    logic [5:0]   buf_wbase;
    logic [255:0] buf_wdata;

    assign nk        = nk_of(alg_q);
    assign nw        = nw_of(alg_q);
    // One extra bit: the last AES-256 step lands on 64.
    assign wptr_next = {1'b0, wptr_q} + {3'b000, nk};

    Key_Expansion_new u_step (
        .in        (key_q),
        .i_Nk      (iter_q),
        .Algorithm (alg_q),
        .out       (step_out)
    );

    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        alg_d        = alg_q;
        wptr_d       = wptr_q;
        iter_d       = iter_q;
        keys_ready_d = keys_ready_q;
        nr_d         = nr_q;
        buf_wr       = 1'b0;
        buf_wbase    = wptr_q;
        buf_wdata    = step_out;
        buf_we       = '0;

        key_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
        handshake = key_valid && key_ready;
        accept    = handshake && (alg != ALG_ILL);
        alg_err_d = handshake && (alg == ALG_ILL);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    key_d        = key_in;
                    alg_d        = alg;
                    keys_ready_d = 1'b0;
                    state_d      = ST_LOAD;
                end
            end
            ST_LOAD: begin
                buf_wr    = 1'b1;
                buf_wbase = 6'd0;
                buf_wdata = key_q;
                wptr_d    = 6'(nk);
                iter_d    = 4'd1;
                state_d   = ST_EXPAND;
            end
            ST_EXPAND: begin
                buf_wr = 1'b1;
                key_d  = step_out;
                wptr_d = wptr_next[5:0];
                iter_d = iter_q + 4'd1;
                if (wptr_next >= {1'b0, nw}) begin
                    state_d      = ST_DONE;
                    keys_ready_d = 1'b1;
                    nr_d         = nr_of(alg_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The final step of 192/256 produces more words than the schedule holds; drop the overflow.
        for (int j = 0; j < 8; j++) begin
            buf_we[j] = buf_wr && (j < int'(nk)) && (int'(buf_wbase) + j < int'(nw));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            key_q        <= '0;
            alg_q        <= ALG_128;
            wptr_q       <= '0;
            iter_q       <= '0;
            keys_ready_q <= 1'b0;
            nr_q         <= '0;
            alg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            alg_q        <= alg_d;
            wptr_q       <= wptr_d;
            iter_q       <= iter_d;
            keys_ready_q <= keys_ready_d;
            nr_q         <= nr_d;
            alg_err_q    <= alg_err_d;
        end
    end

    aes_rk_buffer #(
        .MAX_WORDS (MAX_WORDS)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .we_i      (buf_we),
        .wbase_i   (buf_wbase),
        .wdata_i   (buf_wdata),
        .round_i   (rk_idx),
        .rd_zero_i (rk_idx > nr_q),
        .rdata_o   (rk_out)
    );

    assign keys_ready = keys_ready_q;
    assign nr         = nr_q;
    assign alg_err    = alg_err_q;

endmodule
